pipo_arbiter: RTL and testbench

PIPO_ARBITER -- requirements
Module: pipo_arbiter

---
 rtl/pipo_arbiter.sv | 71 +++++++
 tb/tb_pipo_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipo_arbiter.sv
// pipo_arbiter: round-robin arbiter loading one of four requesters' data into a shared register
module pipo_arbiter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  input  logic [n-1:0] d2,
  input  logic [n-1:0] d3,
  input  logic         hold,
  output logic [3:0]   ack,
  output logic [n-1:0] po,
  output logic [1:0]   owner,
  output logic         po_valid
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t       state_q, state_d;
  logic [n-1:0] po_q, po_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   ptr_q, ptr_d;
  logic         po_valid_q, po_valid_d;
  logic [3:0]   elig;
  logic [1:0]   win, idx;
  logic         found, grant;
  // the previous winner is masked for one cycle so a req still high while its ack is seen is not written twice
  assign elig = req & ~ack;
  // round-robin search from ptr; descending offsets let the nearest eligible index overwrite farther ones
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  // a grant (WRITE) happens only when not held and something is eligible; otherwise everything holds
  always_comb begin
    grant = !hold && found;
    state_d = grant ? WRITE : IDLE;
    po_d = !grant ? po_q : win == 2'd0 ? d0 : win == 2'd1 ? d1 : win == 2'd2 ? d2 : d3;
    owner_d = grant ? win : owner_q;
    ptr_d = grant ? win + 2'd1 : ptr_q;
    po_valid_d = po_valid_q | grant;
  end
  // state register, asynchronously cleared by active-low rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      po_q <= '0;
      owner_q <= '0;
      ptr_q <= '0;
      po_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      po_q <= po_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      po_valid_q <= po_valid_d;
    end
  end
  assign ack = (state_q == WRITE) ? 4'b0001 << owner_q : 4'b0000;
  assign po = po_q;
  assign owner = owner_q;
  assign po_valid = po_valid_q;
endmodule

// File: tb/tb_pipo_arbiter.sv
// tb_pipo_arbiter: directed-vector check of the round-robin parallel-out arbiter
module tb_pipo_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic       hold = 1'b0;
  logic [3:0] ack;
  logic [3:0] po;
  logic [1:0] owner;
  logic       po_valid;
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] rr_po [5];
  logic [3:0] rr_ack [5];

  pipo_arbiter #(.n(4)) dut (
    .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .hold(hold), .ack(ack), .po(po), .owner(owner), .po_valid(po_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_po", po, 4'b0000);
    chk("rst_owner", {2'b00, owner}, 4'd0);
    chk("rst_valid", {3'b000, po_valid}, 4'd0);
    chk("rst_ack", ack, 4'b0000);
    rst = 1'b1;
    req = 4'b0100; d2 = 4'b1100; d0 = 4'b1111; d1 = 4'b0111; d3 = 4'b0011;
    tick();
    chk("single_po", po, 4'b1100);
    chk("single_owner", {2'b00, owner}, 4'd2);
    chk("single_ack", ack, 4'b0100);
    chk("single_valid", {3'b000, po_valid}, 4'd1);
    req = 4'b0000;
    tick();
    chk("single_ack_drop", ack, 4'b0000);
    chk("single_po_hold", po, 4'b1100);
    req = 4'b0011; d0 = 4'b0001; d1 = 4'b0010;
    tick();
    chk("wrap_owner0", {2'b00, owner}, 4'd0);
    chk("wrap_po0", po, 4'b0001);
    chk("wrap_ack0", ack, 4'b0001);
    tick();
    chk("wrap_owner1", {2'b00, owner}, 4'd1);
    chk("wrap_po1", po, 4'b0010);
    chk("wrap_ack1", ack, 4'b0010);
    req = 4'b0000;
    tick();
    chk("wrap_idle_ack", ack, 4'b0000);
    req = 4'b0001; hold = 1'b1; d0 = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_po", po, 4'b0010);
      chk("hold_ack", ack, 4'b0000);
    end
    hold = 1'b0;
    tick();
    chk("hold_rel_ack", ack, 4'b0001);
    chk("hold_rel_po", po, 4'b0101);
    req = 4'b0000;
    tick();
    req = 4'b1000; d3 = 4'b1010;
    tick();
    chk("midrst_ack3", ack, 4'b1000);
    chk("midrst_po3", po, 4'b1010);
    #2 rst = 1'b0;
    #1;
    chk("async_po", po, 4'b0000);
    chk("async_ack", ack, 4'b0000);
    chk("async_owner", {2'b00, owner}, 4'd0);
    chk("async_valid", {3'b000, po_valid}, 4'd0);
    tick();
    chk("inrst_nogrant", ack, 4'b0000);
    #3 rst = 1'b1;
    tick();
    chk("postrst_ack", ack, 4'b1000);
    chk("postrst_owner", {2'b00, owner}, 4'd3);
    chk("postrst_po", po, 4'b1010);
    req = 4'b0000;
    tick();
    rr_po = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
    rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req = 4'b1111; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rr_po%0d", i), po, rr_po[i]);
      chk($sformatf("rr_ack%0d", i), ack, rr_ack[i]);
    end
    req = 4'b0000;
    tick();
    tick();
    chk("final_ack", ack, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
